pong_match_ctrl: RTL and testbench
==================================

// Module: pong_match_ctrl
// PURPOSE
//  Match sequencer for the two-player pong datapath. Watches the ball position against
//  the screen edges, keeps both scores, and gates the ball mover (run/hold/re-centre).
//  Sits between the button inputs and the ball/paddle blocks. Runs in the 1 ms game-tick domain.
// PARAMETERS
//  H_ACTIVE     640   visible width in pixels; right miss line is H_ACTIVE-MISS_MARGIN
//  MISS_MARGIN  4     left miss when x_ball <= MISS_MARGIN; right miss when x_ball >= H_ACTIVE-MISS_MARGIN
//  SERVE_DELAY  1000  ticks the ball is held at centre before each serve (1..65535)
//  POINT_HOLD   500   ticks frozen after a point before the next serve (1..65535)
//  WIN_SCORE    5     points needed to win (1..15)
// PORTS
//  clk_1ms      in   1   game tick clock
//  reset        in   1   synchronous, active-high reset
//  start_n      in   1   start/restart button, active-low
//  pause_n      in   1   pause button, active-low (present only with PONG_PAUSE_EN)
//  x_ball       in   10  ball centre x from the ball block
//  ball_run     out  1   1 = ball block may advance this tick
//  ball_center  out  1   one-tick pulse: ball block reloads to screen centre
//  serve_dir    out  1   next/current serve direction: 0 = toward P1 (left), 1 = toward P2 (right)
//  score1       out  4   P1 (left) score
//  score2       out  4   P2 (right) score
//  game_over    out  1   1 while in GAME_OVER
//  winner       out  1   valid when game_over: 0 = P1, 1 = P2
//  state_out    out  3   current FSM state code (debug)
// BEHAVIOUR
//  - Reset (sync, active-high, wins over every other input): state=IDLE, scores=0, ball_run=0,
//    ball_center=0, serve_dir=1, game_over=0, winner=0, tick counter=0, button history=1 (released).
//  - Button presses are falling edges: start_n registered; press = prev==1 && now==0. Holding a
//    button produces exactly one press. The same applies to pause_n.
//  - States (state_out code): IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4, PAUSE=5.
//  - IDLE: all outputs idle. Start press -> SERVE.
//  - SERVE: ball_center=1 on the first tick only. ball_run=0. A 16-bit counter counts
//    SERVE_DELAY ticks; on the last tick -> PLAY, with ball_run=1 from the first PLAY tick.
//  - PLAY: ball_run=1. Miss detection is combinational on x_ball and registered on the tick edge:
//    left miss -> score2+1, serve_dir=0, -> POINT; right miss -> score1+1, serve_dir=1, -> POINT.
//    If both conditions are true (only possible when MISS_MARGIN is misconfigured), the left miss wins.
//    The new score is visible on the same edge that enters POINT; ball_run=0 from that tick.
//  - POINT: ball_run=0 for POINT_HOLD ticks. Then, if score1==WIN_SCORE or score2==WIN_SCORE
//    -> GAME_OVER with winner set; otherwise -> SERVE.
//  - GAME_OVER: game_over=1, ball_run=0, scores held. Start press: clear scores, serve_dir=1 -> SERVE.
//    A start held down since before entry does not restart the match (edge rule).
//  - Scores never exceed WIN_SCORE, so there is no wrap. Start presses outside IDLE/GAME_OVER are ignored.
//  - The counter clears on every state entry. Reset during any state aborts to IDLE next tick.
// CONFIGURATION
//  PONG_PAUSE_EN defined: the pause_n port exists. A pause press in PLAY -> PAUSE: ball_run=0;
//    scores, serve_dir and counter are frozen; miss detection is disabled. A pause press in PAUSE -> PLAY.
//    Pause presses in other states are ignored. Start presses in PAUSE are ignored.
//  PONG_PAUSE_EN undefined: no pause_n port; PAUSE is unreachable; state code 5 is never produced.
// TESTING
//  1 Assert reset 2 ticks, x_ball=320 -> state_out=0, scores 0/0, ball_run=0, serve_dir=1, game_over=0.
//  2 start_n 1->0 (held low) -> ball_center high exactly 1 tick, ball_run=0 for 1000 ticks, then 1; no second serve.
//  3 In PLAY, x_ball=3 -> next tick score2=1, serve_dir=0, ball_run=0, state=3; after 500 ticks state=1.
//  4 Five right misses (x_ball=637) -> score1=5, game_over=1, winner=0; start held low gives no
//    restart; release and press again -> scores 0/0, state=1.
//  5 Reset asserted mid-SERVE and mid-POINT (score2=3) -> next tick IDLE, scores 0, ball_run=0.
//  6 PONG_PAUSE_EN: pause press in PLAY -> ball_run=0 for 200 ticks with x_ball=2, no score change;
//    second press -> PLAY, then left miss is scored.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/point/game-over control and score keeping in the 1 ms tick domain.
// Optional pause feature enabled by defining PONG_PAUSE_EN (adds the pause_n port and PAUSE state).
module pong_match_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int MISS_MARGIN = 4,
  parameter int SERVE_DELAY = 1000,
  parameter int POINT_HOLD  = 500,
  parameter int WIN_SCORE   = 5
) (
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic       start_n,
`ifdef PONG_PAUSE_EN
  input  logic       pause_n,
`endif
  input  logic [9:0] x_ball,
  output logic       ball_run,
  output logic       ball_center,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4,
    PAUSE     = 3'd5
  } state_t;

  localparam logic [15:0] SERVE_LAST = 16'(SERVE_DELAY - 1);
  localparam logic [15:0] POINT_LAST = 16'(POINT_HOLD - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [9:0]  LEFT_LINE  = 10'(MISS_MARGIN);
  localparam logic [9:0]  RIGHT_LINE = 10'(H_ACTIVE - MISS_MARGIN);

  state_t      state;
  logic [15:0] cnt;
  logic        start_prev;
  logic        start_press;
  logic        pause_press;
  logic        miss_left;
  logic        miss_right;

  assign start_press = start_prev & ~start_n;
  assign miss_left   = (x_ball <= LEFT_LINE);
  assign miss_right  = (x_ball >= RIGHT_LINE);
  assign state_out   = state;

`ifdef PONG_PAUSE_EN
  logic pause_prev;
  assign pause_press = pause_prev & ~pause_n;

  always_ff @(posedge clk_1ms) begin
    if (reset) pause_prev <= 1'b1;
    else       pause_prev <= pause_n;
  end
`else
  assign pause_press = 1'b0;
`endif

  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      score1      <= '0;
      score2      <= '0;
      ball_run    <= 1'b0;
      ball_center <= 1'b0;
      serve_dir   <= 1'b1;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      start_prev  <= 1'b1;
    end else begin
      start_prev  <= start_n;
      ball_center <= 1'b0;
      case (state)
        IDLE: begin
          if (start_press) begin
            state       <= SERVE;
            cnt         <= '0;
            ball_center <= 1'b1;
          end
        end
        SERVE: begin
          if (cnt == SERVE_LAST) begin
            state    <= PLAY;
            cnt      <= '0;
            ball_run <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        PLAY: begin
          // Pause takes precedence so a press on a miss tick freezes the rally unscored.
          if (pause_press) begin
            state    <= PAUSE;
            ball_run <= 1'b0;
          end else if (miss_left) begin
            state     <= POINT;
            cnt       <= '0;
            ball_run  <= 1'b0;
            score2    <= score2 + 4'd1;
            serve_dir <= 1'b0;
          end else if (miss_right) begin
            state     <= POINT;
            cnt       <= '0;
            ball_run  <= 1'b0;
            score1    <= score1 + 4'd1;
            serve_dir <= 1'b1;
          end
        end
        POINT: begin
          if (cnt == POINT_LAST) begin
            cnt <= '0;
            if (score1 == WIN || score2 == WIN) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
              winner    <= (score2 == WIN);
            end else begin
              state       <= SERVE;
              ball_center <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAME_OVER: begin
          if (start_press) begin
            state       <= SERVE;
            cnt         <= '0;
            score1      <= '0;
            score2      <= '0;
            serve_dir   <= 1'b1;
            game_over   <= 1'b0;
            ball_center <= 1'b1;
          end
        end
        PAUSE: begin
          if (pause_press) begin
            state    <= PLAY;
            ball_run <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          ball_run <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: a tick-level reference model queues expected outputs,
// a monitor compares them one tick later. Pause scenarios are included when PONG_PAUSE_EN is defined.
module tb_pong_match_ctrl;

  localparam int H  = 640;
  localparam int MM = 4;
  localparam int SD = 1000;
  localparam int PH = 500;
  localparam int W  = 5;

  localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_POINT = 3, P_OVER = 4, P_PAUSE = 5;

  logic       clk_1ms = 1'b0;
  logic       reset   = 1'b1;
  logic       start_n = 1'b1;
`ifdef PONG_PAUSE_EN
  logic       pause_n = 1'b1;
`endif
  logic [9:0] x_ball  = 10'd320;
  logic       ball_run, ball_center, serve_dir, game_over, winner;
  logic [3:0] score1, score2;
  logic [2:0] state_out;

  always #5 clk_1ms = ~clk_1ms;

  pong_match_ctrl #(
    .H_ACTIVE(H), .MISS_MARGIN(MM), .SERVE_DELAY(SD), .POINT_HOLD(PH), .WIN_SCORE(W)
  ) dut (
    .clk_1ms(clk_1ms), .reset(reset), .start_n(start_n),
`ifdef PONG_PAUSE_EN
    .pause_n(pause_n),
`endif
    .x_ball(x_ball), .ball_run(ball_run), .ball_center(ball_center), .serve_dir(serve_dir),
    .score1(score1), .score2(score2), .game_over(game_over), .winner(winner), .state_out(state_out)
  );

  typedef struct {
    int phase; int s1; int s2;
    bit run; bit ctr; bit dir; bit go; bit win;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;

  // Reference model: phase plus ticks remaining in it, advanced once per tick.
  int m_phase = P_IDLE, m_rem = 0, m_s1 = 0, m_s2 = 0;
  bit m_run = 0, m_ctr = 0, m_dir = 1, m_go = 0, m_win = 0;
  bit m_sprev = 1, m_pprev = 1;

  function automatic void model_step(input bit r, input bit s, input bit p, input int x);
    bit sp, pp;
    sp = m_sprev && !s;
    pp = m_pprev && !p;
`ifndef PONG_PAUSE_EN
    pp = 0;
`endif
    m_sprev = s; m_pprev = p;
    if (r) begin
      m_phase = P_IDLE; m_rem = 0; m_s1 = 0; m_s2 = 0;
      m_run = 0; m_ctr = 0; m_dir = 1; m_go = 0; m_win = 0;
      m_sprev = 1; m_pprev = 1;
      return;
    end
    m_ctr = 0;
    case (m_phase)
      P_IDLE: if (sp) begin m_phase = P_SERVE; m_rem = SD; m_ctr = 1; end
      P_SERVE: begin
        m_rem--;
        if (m_rem == 0) begin m_phase = P_PLAY; m_run = 1; end
      end
      P_PLAY: begin
        if (pp) begin m_phase = P_PAUSE; m_run = 0; end
        else if (x <= MM) begin m_s2++; m_dir = 0; m_phase = P_POINT; m_rem = PH; m_run = 0; end
        else if (x >= H - MM) begin m_s1++; m_dir = 1; m_phase = P_POINT; m_rem = PH; m_run = 0; end
      end
      P_POINT: begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_s1 == W || m_s2 == W) begin m_phase = P_OVER; m_go = 1; m_win = (m_s2 == W); end
          else begin m_phase = P_SERVE; m_rem = SD; m_ctr = 1; end
        end
      end
      P_OVER: if (sp) begin
        m_s1 = 0; m_s2 = 0; m_dir = 1; m_go = 0; m_phase = P_SERVE; m_rem = SD; m_ctr = 1;
      end
      P_PAUSE: if (pp) begin m_phase = P_PLAY; m_run = 1; end
      default: ;
    endcase
  endfunction

  task automatic drive(input bit r, input bit s, input bit p, input int x);
    exp_t e;
    @(negedge clk_1ms);
    reset = r; start_n = s; x_ball = 10'(x);
`ifdef PONG_PAUSE_EN
    pause_n = p;
`endif
    model_step(r, s, p, x);
    e.phase = m_phase; e.s1 = m_s1; e.s2 = m_s2; e.run = m_run; e.ctr = m_ctr;
    e.dir = m_dir; e.go = m_go; e.win = m_win;
    q.push_back(e);
  endtask

  task automatic run_until(input int target, input int limit, input bit s, input int x, input string nm);
    int n;
    n = 0;
    while (m_phase != target && n < limit) begin
      drive(0, s, 1, x);
      n++;
    end
    if (m_phase != target) begin
      tests++; fails++;
      $display("FAIL wait_%s: phase %0d after %0d ticks, required %0d", nm, m_phase, n, target);
    end
  endtask

  function automatic void chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s at %0t: got %0d required %0d", nm, $time, act, exp_v);
    end
  endfunction

  // Monitor: the DUT presents a fresh output set every tick.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_1ms);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("state_out", int'(state_out), e.phase);
        chk("ball_run", int'(ball_run), int'(e.run));
        chk("ball_center", int'(ball_center), int'(e.ctr));
        chk("serve_dir", int'(serve_dir), int'(e.dir));
        chk("score1", int'(score1), e.s1);
        chk("score2", int'(score2), e.s2);
        chk("game_over", int'(game_over), int'(e.go));
        if (e.go) chk("winner", int'(winner), int'(e.win));
      end
    end
  end

  initial begin
    int r;
    int x;
    bit rs, s, p;
    // Reset and idle
    drive(1, 1, 1, 320);
    drive(1, 1, 1, 320);
    repeat (3) drive(0, 1, 1, 320);
    // Held start: single serve, then play with near-boundary positions that are not misses
    run_until(P_PLAY, SD + 5, 0, 320, "first_play");
    drive(0, 0, 1, 5);
    drive(0, 0, 1, H - MM - 1);
    drive(0, 0, 1, 320);
    // Left miss at x=3, hold, reserve
    drive(0, 0, 1, 3);
    run_until(P_SERVE, PH + 5, 0, 320, "serve_after_point");
    run_until(P_PLAY, SD + 5, 0, 320, "play2");
    // Two more left misses on the boundary value to reach score2=3
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, MM);
      if (i == 0) begin
        run_until(P_PLAY, PH + SD + 5, 0, 320, "play3");
      end
    end
    repeat (100) drive(0, 0, 1, 320);
    drive(1, 0, 1, 320);
    repeat (3) drive(0, 1, 1, 320);
    // Reset mid-serve
    drive(0, 0, 1, 320);
    repeat (300) drive(0, 0, 1, 320);
    drive(1, 0, 1, 320);
    drive(0, 1, 1, 320);
    // Full game of right misses with start held down through game over
    drive(0, 0, 1, 320);
    for (int i = 0; i < W; i++) begin
      run_until(P_PLAY, PH + SD + 5, 0, 320, "game_play");
      drive(0, 0, 1, H - MM);
    end
    run_until(P_OVER, PH + 5, 0, 320, "game_over");
    repeat (50) drive(0, 0, 1, 320);
    repeat (2) drive(0, 1, 1, 320);
    drive(0, 0, 1, 320);
    drive(0, 1, 1, 320);
`ifdef PONG_PAUSE_EN
    run_until(P_PLAY, SD + 5, 1, 320, "pause_play");
    drive(0, 1, 0, 2);
    repeat (200) drive(0, 1, 0, 2);
    drive(0, 1, 1, 2);
    drive(0, 0, 0, 2);
    drive(0, 1, 1, 2);
`endif
    // Randomized traffic
    for (int i = 0; i < 20000; i++) begin
      r  = int'($urandom_range(0, 15));
      if (r == 0)      x = int'($urandom_range(0, 6));
      else if (r == 1) x = int'($urandom_range(633, 639));
      else             x = int'($urandom_range(100, 540));
      rs = ($urandom_range(0, 1999) == 0);
      s  = ($urandom_range(0, 7) != 0);
      p  = ($urandom_range(0, 63) != 0);
      drive(rs, s, p, x);
    end
    @(posedge clk_1ms);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
